// File: rtl/pixel_scan_ctrl_pkg.sv
// Shared constants and FSM encoding for the ISFET pixel scan sequencer.
// The pixel address width is also used by the SPI readout engine.
package pixel_scan_ctrl_pkg;

    localparam int PIX_ADDR_WIDTH  = 8;
    localparam int DEF_PIXEL_NUM   = 16;
    localparam int DEF_ADC_BITS    = 18;
    localparam int DEF_AVG_LOG2    = 2;
    localparam int DEF_DISCARD     = 1;
    localparam int DEF_TIMEOUT_CYC = 4095;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_REQ  = 3'd2,
        ST_WAIT = 3'd3,
        ST_PUSH = 3'd4,
        ST_NEXT = 3'd5,
        ST_DONE = 3'd6
    } scan_state_t;

endpackage

// File: rtl/pixel_avg_acc.sv
// Per-pixel sample averager: drops the warm-up conversions, then sums a
// power-of-two number of signed samples and presents their floored mean.
module pixel_avg_acc
    import pixel_scan_ctrl_pkg::*;
#(
    parameter int ADC_BITS = DEF_ADC_BITS,
    parameter int AVG_LOG2 = DEF_AVG_LOG2,
    parameter int DISCARD  = DEF_DISCARD
) (
    input  logic                       clk_ext,
    input  logic                       rst_ext,
    input  logic                       clr,
    input  logic                       en,
    input  logic signed [ADC_BITS-1:0] din,
    output logic                       count_done,
    output logic signed [ADC_BITS-1:0] avg_out
);

    localparam int ACC_W = ADC_BITS + AVG_LOG2;
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam int DSC_W = $clog2(DISCARD + 2);
    localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'((1 << AVG_LOG2) - 1);
    localparam logic [DSC_W-1:0] DSC_LIM  = DSC_W'(DISCARD);

    logic signed [ACC_W-1:0] acc;
    logic [SMP_W-1:0]        smp_cnt;
    logic [DSC_W-1:0]        dsc_cnt;
    logic                    warm;

    assign warm       = (dsc_cnt == DSC_LIM);
    assign count_done = en && warm && (smp_cnt == LAST_SMP);
    // The accumulator is wide enough for 2^AVG_LOG2 full-scale samples, so
    // the arithmetic shift gives the exact floored mean.
    assign avg_out    = ADC_BITS'(acc >>> AVG_LOG2);

    always_ff @(posedge clk_ext) begin
        if (rst_ext || clr) begin
            acc     <= '0;
            smp_cnt <= '0;
            dsc_cnt <= '0;
        end else if (en) begin
            if (!warm) begin
                dsc_cnt <= dsc_cnt + DSC_W'(1);
            end else begin
                acc     <= acc + ACC_W'(din);
                smp_cnt <= smp_cnt + SMP_W'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_scan_ctrl.sv
// Scan sequencer: walks the pixel array through the readout engine, averages
// each pixel's conversions and hands one result per pixel to the UART path.
module pixel_scan_ctrl
    import pixel_scan_ctrl_pkg::*;
#(
    parameter int PIXEL_NUM   = DEF_PIXEL_NUM,
    parameter int ADDR_WIDTH  = PIX_ADDR_WIDTH,
    parameter int ADC_BITS    = DEF_ADC_BITS,
    parameter int AVG_LOG2    = DEF_AVG_LOG2,
    parameter int DISCARD     = DEF_DISCARD,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                         clk_ext,
    input  logic                         rst_ext,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         rotate_cfg,
    input  logic                         adc_int_cfg,
    output logic                         busy,
    output logic                         done,
    output logic                         eng_rstb,
    output logic                         pix_rd_ena,
    output logic [ADDR_WIDTH-1:0]        pix_select,
    output logic                         rotate_flag,
    output logic                         adc_int_flag,
    input  logic                         adc_valid,
    input  logic signed [ADC_BITS-1:0]   adc_data,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [ADDR_WIDTH-1:0]        res_addr,
    output logic signed [ADC_BITS-1:0]   res_data,
    output logic                         res_err,
    output logic                         err_sticky
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(PIXEL_NUM - 1);

    scan_state_t      state;
    logic             start_q;
    logic             arm_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             acc_en;
    logic             acc_clr;
    logic             last_smp;
    logic             tmo_hit;

    // A timed-out pixel clears the accumulator so its result word reads zero.
    assign acc_en  = (state == ST_WAIT) && adc_valid;
    assign tmo_hit = (state == ST_WAIT) && !adc_valid && (tmo_cnt == TMO_LAST);
    assign acc_clr = (state == ST_REQ) || tmo_hit;

    pixel_avg_acc #(
        .ADC_BITS (ADC_BITS),
        .AVG_LOG2 (AVG_LOG2),
        .DISCARD  (DISCARD)
    ) u_avg_acc (
        .clk_ext    (clk_ext),
        .rst_ext    (rst_ext),
        .clr        (acc_clr),
        .en         (acc_en),
        .din        (adc_data),
        .count_done (last_smp),
        .avg_out    (res_data)
    );

    always_ff @(posedge clk_ext) begin
        if (rst_ext) begin
            state        <= ST_IDLE;
            start_q      <= 1'b0;
            arm_cnt      <= 1'b0;
            tmo_cnt      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            eng_rstb     <= 1'b0;
            pix_rd_ena   <= 1'b0;
            pix_select   <= '0;
            rotate_flag  <= 1'b0;
            adc_int_flag <= 1'b0;
            res_valid    <= 1'b0;
            res_addr     <= '0;
            res_err      <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            start_q    <= start;
            done       <= 1'b0;
            pix_rd_ena <= 1'b0;
            if (abort) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                eng_rstb  <= 1'b0;
                res_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        eng_rstb <= 1'b0;
                        if (start && !start_q) begin
                            state        <= ST_ARM;
                            busy         <= 1'b1;
                            arm_cnt      <= 1'b0;
                            pix_select   <= '0;
                            rotate_flag  <= rotate_cfg;
                            adc_int_flag <= adc_int_cfg;
                            err_sticky   <= 1'b0;
                        end
                    end
                    ST_ARM: begin
                        if (arm_cnt) begin
                            state      <= ST_REQ;
                            eng_rstb   <= 1'b1;
                            pix_rd_ena <= 1'b1;
                        end else begin
                            arm_cnt <= 1'b1;
                        end
                    end
                    ST_REQ: begin
                        tmo_cnt <= '0;
                        state   <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (acc_en) begin
                            tmo_cnt <= '0;
                            if (last_smp) begin
                                state     <= ST_PUSH;
                                eng_rstb  <= 1'b0;
                                res_valid <= 1'b1;
                                res_addr  <= pix_select;
                                res_err   <= 1'b0;
                            end
                        end else if (tmo_hit) begin
                            state      <= ST_PUSH;
                            eng_rstb   <= 1'b0;
                            res_valid  <= 1'b1;
                            res_addr   <= pix_select;
                            res_err    <= 1'b1;
                            err_sticky <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    ST_PUSH: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            state     <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        if (pix_select == LAST_PIX) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            pix_select <= pix_select + ADDR_WIDTH'(1);
                            arm_cnt    <= 1'b0;
                            state      <= ST_ARM;
                        end
                    end
                    ST_DONE: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/pixel_scan_ctrl.md
# pixel_scan_ctrl

Sequencer that scans the ISFET pixel array through the SPI readout engine, one pixel at a time. For each address it resets and arms the engine, discards warm-up conversions, averages a power-of-two number of ADC results, and hands one result word per pixel to the UART path over a valid/ready handshake. It sits between the board-level control (start/abort switches) and the existing readout engine and UART blocks.

## Interface
- PIXEL_NUM, 16, pixels scanned per run (addresses 0..PIXEL_NUM-1)
- ADDR_WIDTH, 8, pixel address width
- ADC_BITS, 18, signed ADC result width
- AVG_LOG2, 2, log2 of samples averaged per pixel (0..4)
- DISCARD, 1, conversions dropped per pixel before averaging
- TIMEOUT_CYC, 4095, max cycles to wait for one conversion
- clk_ext  in  1  system clock, all logic on rising edge
- rst_ext  in  1  synchronous, active-high reset
- start  in  1  level; rising edge sampled in IDLE begins a scan
- abort  in  1  level; returns the block to IDLE
- rotate_cfg, adc_int_cfg  in  1  copied to engine flags at scan start
- busy  out  1  high from scan accept to DONE exit
- done  out  1  one-cycle pulse at end of scan
- eng_rstb  out  1  active-low reset to readout engine
- pix_rd_ena  out  1  engine start request
- pix_select  out  ADDR_WIDTH  current pixel address
- rotate_flag, adc_int_flag  out  1  latched config
- adc_valid  in  1  one-cycle pulse, adc_data valid
- adc_data  in  ADC_BITS  signed conversion result
- res_valid  out  1  result available
- res_ready  in  1  UART path accepts result
- res_addr  out  ADDR_WIDTH  pixel of the result
- res_data  out  ADC_BITS  signed averaged result
- res_err  out  1  result produced by timeout
- err_sticky  out  1  any timeout since last scan start

## Operation
- Reset values: all outputs 0, except eng_rstb=0 (engine held in reset). State IDLE.
- States and transitions:
  - IDLE: eng_rstb=0. Edge on start → ARM. On accept, latch cfg flags, clear err_sticky, set pix_select=0.
  - ARM: eng_rstb=0 for exactly 2 cycles → REQ.
  - REQ: eng_rstb=1, pix_rd_ena=1 for 1 cycle → WAIT.
  - WAIT: count adc_valid pulses. The first DISCARD pulses are dropped. The next 2^AVG_LOG2 are summed.
    - Last sample → PUSH.
    - Timeout counter reaching TIMEOUT_CYC → PUSH with res_err=1, res_data=0, err_sticky=1.
  - PUSH: eng_rstb=0, res_valid=1, outputs stable until res_valid&&res_ready → NEXT.
  - NEXT: if pix_select==PIXEL_NUM-1 → DONE, else pix_select+1 → ARM.
  - DONE: done=1 for 1 cycle, busy=0 → IDLE.
- Arithmetic:
  - Accumulator is signed, width ADC_BITS+AVG_LOG2, sign-extended adds, no overflow possible.
  - res_data = accumulator >>> AVG_LOG2 (arithmetic shift, floor toward −inf).
- Timeout counter clears on each accepted or discarded adc_valid and on REQ entry.
- adc_valid outside WAIT is ignored.
- abort has priority over every transition. Next cycle: IDLE, res_valid=0, busy=0, no done pulse, eng_rstb=0.
- start held high does not retrigger; only a 0→1 edge seen in IDLE starts a scan.
- rst_ext mid-scan behaves as abort, and also clears err_sticky and the edge detector.

## Timing
- start edge → ARM in 1 cycle; busy rises the same edge.
- ARM→REQ: 2 cycles. REQ→WAIT: 1 cycle.
- adc_valid of the last sample → res_valid high on the next rising edge.
- res_valid&&res_ready on cycle N → NEXT at N+1, ARM of the next pixel at N+2.
- Per-pixel overhead excluding conversions and ready stall: 6 cycles.
- pix_select and the flags are stable from ARM through PUSH; they change only in NEXT.
- Back-pressure: res_ready may stay low indefinitely. The engine stays in reset meanwhile.

## Structure
- Shared package/header:
  - FSM state encodings (IDLE..DONE, 3 bits).
  - Default parameter constants.
  - Pixel-address width constant, shared with the readout engine.
- One sub-module: pixel_avg_acc. Signed accumulator plus sample/discard counters. Interface: clr, en, din, count_done, avg_out.
- FSM, timeout counter and handshake registers live in the top.

## Test plan
- PIXEL_NUM=4, AVG_LOG2=2, DISCARD=1, res_ready=1, engine model returns 100,10,20,30,40 per pixel → res_data=25 for addr 0..3, done one pulse, busy low after.
- Negative samples −3,−4,−4,−4 (after discard) → res_data=−4 (floor of −3.75).
- res_ready held low 50 cycles at pixel 1 → res_valid, res_addr=1, res_data stable for 50 cycles; no pixel 2 request until handshake.
- Engine silent on pixel 2, TIMEOUT_CYC=100 → after 100 cycles res_err=1, res_data=0, err_sticky=1; pixel 3 then proceeds normally.
- abort asserted in WAIT of pixel 1 → next cycle IDLE, busy=0, eng_rstb=0, no res_valid, no done; a new start scans from address 0.
- start held high across the whole scan → exactly one scan; rst_ext pulse mid-PUSH → all outputs at reset values the next cycle.
